// File: rtl/eka_pkg.sv
// Shared definitions for the Eka core: data width, RV32M funct3 codes and the
// muldiv_unit state encoding.
package eka_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/divide_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module divide_step
    import eka_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            dividend_bit_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN+1:0] diff;

    always_comb begin
        diff    = {1'b0, rem_i, dividend_bit_i} - {2'b00, divisor_i};
        q_bit_o = ~diff[XLEN+1];
        rem_o   = q_bit_o ? diff[XLEN-1:0] : {rem_i[XLEN-2:0], dividend_bit_i};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_DIV_EN to include the divider; otherwise divide ops return 0.
module muldiv_unit #(
    parameter int unsigned XLEN = eka_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            kill,
    output logic            busy,
    output logic            wb_valid,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);
    import eka_pkg::*;

    state_e              state_q, state_d;
    logic [4:0]          count_q, count_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic [XLEN-1:0]     mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic                neg_q, neg_d;
    logic                special_q, special_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [4:0]          wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;

    logic                accept, a_signed, b_signed, sign_a, sign_b, special_in;
    logic [XLEN-1:0]     abs_a, abs_b, special_res, mul_res, fix_result;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, prod_fixed, step_next;

    assign start_ready = (state_q == StIdle) && rst_n && !kill;
    assign accept      = start_valid && start_ready;
    assign busy        = (state_q != StIdle);
    assign wb_valid    = (state_q == StDone) && !kill;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;

    always_comb begin
        a_signed = funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        b_signed = funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
        sign_a   = a_signed && rs1_data[XLEN-1];
        sign_b   = b_signed && rs2_data[XLEN-1];
        abs_a    = sign_a ? -rs1_data : rs1_data;
        abs_b    = sign_b ? -rs2_data : rs2_data;
    end

    // Multiply: accumulate into the high half, shift the multiplier out of the low half.
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        mul_next   = {mul_sum, acc_q[XLEN-1:1]};
        prod_fixed = neg_q ? -acc_q : acc_q;
        mul_res    = (op_q == F3_MUL) ? prod_fixed[XLEN-1:0] : prod_fixed[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    logic            div_zero, div_ovf, q_bit;
    logic [XLEN-1:0] rem_next, div_sel, div_res;

    divide_step u_divide_step (
        .rem_i          (acc_q[2*XLEN-1:XLEN]),
        .divisor_i      (mag_b_q),
        .dividend_bit_i (acc_q[XLEN-1]),
        .rem_o          (rem_next),
        .q_bit_o        (q_bit)
    );

    always_comb begin
        div_zero    = (rs2_data == '0);
        div_ovf     = (funct3 == F3_DIV || funct3 == F3_REM) &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        special_in  = funct3[2] && (div_zero || div_ovf);
        if (funct3[1]) begin
            special_res = div_zero ? rs1_data : '0;
        end else begin
            special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        end
        // Low half holds the dividend shifting out and the quotient shifting in.
        step_next  = op_q[2] ? {rem_next, acc_q[XLEN-2:0], q_bit} : mul_next;
        div_sel    = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_res    = neg_q ? -div_sel : div_sel;
        fix_result = special_q ? acc_q[XLEN-1:0] : (op_q[2] ? div_res : mul_res);
    end
`else
    always_comb begin
        special_in  = funct3[2];
        special_res = '0;
        step_next   = mul_next;
        fix_result  = special_q ? acc_q[XLEN-1:0] : mul_res;
    end
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        rd_d      = rd_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        special_d = special_q;
        acc_d     = acc_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = funct3;
                    rd_d      = rd_addr;
                    mag_a_d   = abs_a;
                    mag_b_d   = abs_b;
                    neg_d     = (funct3 == F3_REM || funct3 == F3_REMU) ? sign_a
                                                                        : (sign_a ^ sign_b);
                    special_d = special_in;
                    count_d   = '0;
                    if (special_in) begin
                        acc_d   = {{XLEN{1'b0}}, special_res};
                        state_d = StFix;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, funct3[2] ? abs_a : abs_b};
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d   = step_next;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!kill) begin
                    wb_data_d = fix_result;
                    wb_addr_d = rd_q;
                end
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill && state_q != StIdle) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            acc_q     <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            acc_q     <= acc_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus kill and reset sequences.
// Expectations for divide ops follow MULDIV_DIV_EN.
module tb_muldiv_unit;
    import eka_pkg::*;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        int          exp_cycle;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        kill = 1'b0;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .funct3      (funct3),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rd_addr     (rd_addr),
        .kill        (kill),
        .busy        (busy),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [31:0] d, input int cyc);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.exp_data = d; v.exp_cycle = cyc;
        return v;
    endfunction

    // Starts at a negedge in an idle cycle (cycle 0) and watches cycles 1..40.
    task automatic run_op(input vec_t v, input string name);
        int          wb_cnt;
        int          wb_cyc;
        logic [31:0] got_data;
        logic [4:0]  got_addr;
        wb_cnt = 0; wb_cyc = -1; got_data = '0; got_addr = '0;
        funct3 = v.f3; rs1_data = v.a; rs2_data = v.b; rd_addr = v.rd; start_valid = 1'b1;
        #1;
        check({name, " ready"}, 32'(start_ready), 32'd1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_valid = 1'b0;
                funct3 = ~v.f3; rs1_data = ~v.a; rs2_data = ~v.b; rd_addr = ~v.rd;
                check({name, " busy"}, 32'(busy), 32'd1);
            end
            if (wb_valid) begin
                wb_cnt++; wb_cyc = c; got_data = wb_data; got_addr = wb_addr;
            end
        end
        check({name, " data"}, got_data, v.exp_data);
        check({name, " addr"}, 32'(got_addr), 32'(v.rd));
        check({name, " cycle"}, 32'(wb_cyc), 32'(v.exp_cycle));
        check({name, " strobes"}, 32'(wb_cnt), 32'd1);
        check({name, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        vec_t v;
        int   seen;

        vecs[0]  = mk(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34);
        vecs[1]  = mk(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 34);
        vecs[2]  = mk(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 34);
        vecs[3]  = mk(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd10, 32'hFFFF_FFFF, 34);
        vecs[4]  = mk(F3_MUL,    32'd3,          32'd5,         5'd0,  32'd15,        34);
        vecs[5]  = mk(F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd3,  32'hFFFF_FFFD, 34);
        vecs[6]  = mk(F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFF, 34);
        vecs[7]  = mk(F3_DIVU,   32'h1234_5678,  32'd0,         5'd7,  32'hFFFF_FFFF, 2);
        vecs[8]  = mk(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 2);
        vecs[9]  = mk(F3_REMU,   32'd100,        32'd7,         5'd11, 32'd2,         34);
        vecs[10] = mk(F3_REM,    32'hFFFF_FFF9,  32'd0,         5'd12, 32'hFFFF_FFF9, 2);
        vecs[11] = mk(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         2);
        vecs[12] = mk(F3_DIVU,   32'hFFFF_FFFF,  32'h10,        5'd31, 32'h0FFF_FFFF, 34);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst wb_valid", 32'(wb_valid), 32'd0);
        check("rst wb_addr", 32'(wb_addr), 32'd0);
        check("rst wb_data", wb_data, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst ready low", 32'(start_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst ready high", 32'(start_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
`ifndef MULDIV_DIV_EN
            if (v.f3[2]) begin
                v.exp_data  = '0;
                v.exp_cycle = 2;
            end
`endif
            run_op(v, $sformatf("vec%0d", i));
        end

        // Kill in cycle 10 of a MUL, then back-to-back start in cycle 11
        funct3 = F3_MUL; rs1_data = 32'd7; rs2_data = 32'd3; rd_addr = 5'd4; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        seen = 0;
        for (int c = 1; c < 10; c++) begin
            if (wb_valid) seen++;
            @(negedge clk);
        end
        kill = 1'b1;
        #1;
        check("kill c10 wb_valid", 32'(wb_valid), 32'd0);
        check("kill c10 ready", 32'(start_ready), 32'd0);
        @(negedge clk);
        kill = 1'b0;
        #1;
        check("kill c11 busy", 32'(busy), 32'd0);
        check("kill c11 ready", 32'(start_ready), 32'd1);
        check("kill no strobe", 32'(seen), 32'd0);
        run_op(mk(F3_MUL, 32'd3, 32'd5, 5'd9, 32'd15, 34), "b2b");

        // Kill during DONE suppresses the strobe
        funct3 = F3_MUL; rs1_data = 32'd2; rs2_data = 32'd3; rd_addr = 5'd6; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        seen = 0;
        for (int c = 1; c <= 33; c++) begin
            if (wb_valid) seen++;
            @(negedge clk);
        end
        kill = 1'b1;
        #1;
        check("killdone wb_valid", 32'(wb_valid), 32'd0);
        check("killdone busy", 32'(busy), 32'd1);
        check("killdone data", wb_data, 32'd6);
        check("killdone addr", 32'(wb_addr), 32'd6);
        check("killdone early strobe", 32'(seen), 32'd0);
        @(negedge clk);
        kill = 1'b0;
        #1;
        check("killdone idle", 32'(busy), 32'd0);

        // kill and start_valid together in IDLE: not accepted
        funct3 = F3_MUL; rs1_data = 32'd1; rs2_data = 32'd1; rd_addr = 5'd1;
        start_valid = 1'b1; kill = 1'b1;
        #1;
        check("killstart ready", 32'(start_ready), 32'd0);
        @(negedge clk);
        start_valid = 1'b0; kill = 1'b0;
        #1;
        check("killstart busy", 32'(busy), 32'd0);

        // Reset in cycle 20 of a long op
`ifdef MULDIV_DIV_EN
        funct3 = F3_DIVU;
`else
        funct3 = F3_MULHU;
`endif
        rs1_data = 32'd1000; rs2_data = 32'd7; rd_addr = 5'd12; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        seen = 0;
        for (int c = 1; c < 20; c++) begin
            if (wb_valid) seen++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst ready low", 32'(start_ready), 32'd0);
        check("midrst busy before", 32'(busy), 32'd1);
        @(negedge clk);
        check("midrst wb_valid", 32'(wb_valid), 32'd0);
        check("midrst wb_addr", 32'(wb_addr), 32'd0);
        check("midrst wb_data", wb_data, 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst ready held", 32'(start_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst ready after", 32'(start_ready), 32'd1);
        for (int c = 0; c < 40; c++) begin
            if (wb_valid) seen++;
            @(negedge clk);
        end
        check("midrst no strobe", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
